// File: rtl/noc_pkg.sv
// Port index constants and crossbar select helpers shared by allocator, crossbar and route compute.
// No logic; latency n/a.
// No flow control; constants only.
package noc_pkg;

    localparam int LOCAL = 0;
    localparam int X1    = 1;
    localparam int X2    = 2;
    localparam int Y1    = 3;
    localparam int Y2    = 4;

    typedef enum logic {
        OUT_IDLE   = 1'b0,
        OUT_LOCKED = 1'b1
    } out_state_e;

    // Crossbar select value meaning "no input drives this output".
    function automatic int sw_stop(input int num_ports);
        return num_ports;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first request at or above ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is taken.
module rr_arbiter #(
    parameter int N     = 5,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt_oh,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    logic [IDX_W-1:0] cur;

    function automatic int wrap(input int base, input int k);
        int s;
        s = base + k;
        if (s >= N) s = s - N;
        return s;
    endfunction

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cur     = '0;
        for (int k = 0; k < N; k++) begin
            cur = IDX_W'(wrap(int'(ptr), k));
            if (!gnt_any && req[cur]) begin
                gnt_any     = 1'b1;
                gnt_oh[cur] = 1'b1;
                gnt_idx     = cur;
            end
        end
    end

endmodule

// File: rtl/switch_allocator_rr.sv
// Wormhole switch allocator: per-output round-robin arbitration, output locked until tail crosses.
// Latency: request at edge t -> select/lock at t+1, first pop grant in cycle t+1.
// Backpressure: out_busy or en=0 suppresses port_grant; locks and pointers hold.
module switch_allocator_rr #(
    parameter int NUM_PORTS = 5,
    parameter int DST_W     = 3,
    parameter int SW_W      = $clog2(NUM_PORTS + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [NUM_PORTS-1:0]      req_valid,
    input  logic [NUM_PORTS*DST_W-1:0] req_dst,
    input  logic [NUM_PORTS-1:0]      req_tail,
    input  logic [NUM_PORTS-1:0]      out_busy,
    output logic [NUM_PORTS-1:0]      port_grant,
    output logic [NUM_PORTS*SW_W-1:0] out_sw,
    output logic [NUM_PORTS-1:0]      out_lock,
    output logic                      err_dst
);
    import noc_pkg::*;

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [SW_W-1:0] SW_STOP = SW_W'(sw_stop(NUM_PORTS));

    out_state_e           state_q [NUM_PORTS];
    out_state_e           state_d [NUM_PORTS];
    logic [PTR_W-1:0]     owner_q [NUM_PORTS];
    logic [PTR_W-1:0]     owner_d [NUM_PORTS];
    logic [PTR_W-1:0]     ptr_q   [NUM_PORTS];
    logic [PTR_W-1:0]     ptr_d   [NUM_PORTS];
    logic [SW_W-1:0]      sw_q    [NUM_PORTS];
    logic [SW_W-1:0]      sw_d    [NUM_PORTS];

    logic [DST_W-1:0]     dst     [NUM_PORTS];
    logic [NUM_PORTS-1:0] cand    [NUM_PORTS];
    logic [NUM_PORTS-1:0] arb_oh  [NUM_PORTS];
    logic [PTR_W-1:0]     arb_idx [NUM_PORTS];
    logic [NUM_PORTS-1:0] arb_any;
    logic [NUM_PORTS-1:0] dst_bad;
    logic [NUM_PORTS-1:0] owned;
    logic [NUM_PORTS-1:0] taken;
    logic [NUM_PORTS-1:0] win;
    logic [NUM_PORTS-1:0] xfer;

    // Candidates exclude inputs already feeding some locked output.
    always_comb begin
        owned = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (state_q[o] == OUT_LOCKED) owned[owner_q[o]] = 1'b1;
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            dst[i]     = req_dst[i*DST_W +: DST_W];
            dst_bad[i] = req_valid[i] & (32'(dst[i]) >= NUM_PORTS);
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            cand[o] = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                cand[o][i] = req_valid[i] & (32'(dst[i]) == o) & ~owned[i];
            end
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
        rr_arbiter #(
            .N     (NUM_PORTS),
            .IDX_W (PTR_W)
        ) u_arb (
            .req     (cand[o]),
            .ptr     (ptr_q[o]),
            .gnt_oh  (arb_oh[o]),
            .gnt_idx (arb_idx[o]),
            .gnt_any (arb_any[o])
        );
    end

    // Lower-indexed outputs claim contested inputs first; the loser keeps its pointer.
    always_comb begin
        taken      = '0;
        win        = '0;
        xfer       = '0;
        port_grant = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (en && state_q[o] == OUT_IDLE && arb_any[o] && ~|(arb_oh[o] & taken)) begin
                win[o] = 1'b1;
                taken  = taken | arb_oh[o];
            end
            if (en && state_q[o] == OUT_LOCKED && req_valid[owner_q[o]] && !out_busy[o]) begin
                xfer[o]                = 1'b1;
                port_grant[owner_q[o]] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            ptr_d[o]   = ptr_q[o];
            sw_d[o]    = sw_q[o];
            case (state_q[o])
                OUT_IDLE: begin
                    if (win[o]) begin
                        state_d[o] = OUT_LOCKED;
                        owner_d[o] = arb_idx[o];
                        sw_d[o]    = SW_W'(arb_idx[o]);
                        ptr_d[o]   = (32'(arb_idx[o]) == NUM_PORTS - 1) ? '0
                                                                        : arb_idx[o] + PTR_W'(1);
                    end
                end
                OUT_LOCKED: begin
                    if (xfer[o] && req_tail[owner_q[o]]) begin
                        state_d[o] = OUT_IDLE;
                        sw_d[o]    = SW_STOP;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                state_q[o] <= OUT_IDLE;
                owner_q[o] <= '0;
                ptr_q[o]   <= '0;
                sw_q[o]    <= SW_STOP;
            end
            err_dst <= 1'b0;
        end else if (en) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                ptr_q[o]   <= ptr_d[o];
                sw_q[o]    <= sw_d[o];
            end
            if (|dst_bad) err_dst <= 1'b1;
        end
    end

    always_comb begin
        out_sw   = '0;
        out_lock = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            out_sw[o*SW_W +: SW_W] = sw_q[o];
            out_lock[o]            = (state_q[o] == OUT_LOCKED);
        end
    end

endmodule

// File: tb/tb_switch_allocator_rr.sv
// Directed bench: driver pushes hand-computed expectations per cycle, negedge monitor pops and compares.
module tb_switch_allocator_rr;

    localparam int NP  = 5;
    localparam int DW  = 3;
    localparam int SWW = $clog2(NP + 1);
    localparam int S   = 5;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                en = 1'b0;
    logic [NP-1:0]       req_valid = '0;
    logic [NP*DW-1:0]    req_dst = '0;
    logic [NP-1:0]       req_tail = '0;
    logic [NP-1:0]       out_busy = '0;
    logic [NP-1:0]       port_grant;
    logic [NP*SWW-1:0]   out_sw;
    logic [NP-1:0]       out_lock;
    logic                err_dst;

    switch_allocator_rr #(.NUM_PORTS(NP), .DST_W(DW), .SW_W(SWW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .req_valid  (req_valid),
        .req_dst    (req_dst),
        .req_tail   (req_tail),
        .out_busy   (out_busy),
        .port_grant (port_grant),
        .out_sw     (out_sw),
        .out_lock   (out_lock),
        .err_dst    (err_dst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NP-1:0]     pg;
        logic [NP*SWW-1:0] sw;
        logic [NP-1:0]     lock;
        logic              err;
        string             name;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   failures = 0;

    function automatic logic [14:0] p5(input int a0, input int a1, input int a2, input int a3, input int a4);
        return {3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            cmp({cur.name, ".port_grant"}, 32'(port_grant), 32'(cur.pg));
            cmp({cur.name, ".out_sw"},     32'(out_sw),     32'(cur.sw));
            cmp({cur.name, ".out_lock"},   32'(out_lock),   32'(cur.lock));
            cmp({cur.name, ".err_dst"},    32'(err_dst),    32'(cur.err));
        end
    end

    task automatic step(input logic rn, input logic e, input logic [4:0] v, input logic [14:0] d,
                        input logic [4:0] t, input logic [4:0] b, input logic [4:0] epg,
                        input logic [14:0] esw, input logic [4:0] elk, input logic eerr,
                        input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n     = rn;
        en        = e;
        req_valid = v;
        req_dst   = d;
        req_tail  = t;
        out_busy  = b;
        x.pg   = epg;
        x.sw   = esw;
        x.lock = elk;
        x.err  = eerr;
        x.name = nm;
        sb.push_back(x);
    endtask

    logic [14:0] idle_sw;
    logic [14:0] d;

    initial begin
        idle_sw = p5(S, S, S, S, S);

        step(0, 0, 5'b00000, '0, '0, '0, '0, idle_sw, '0, 0, "rst_a");
        step(0, 0, 5'b00000, '0, '0, '0, '0, idle_sw, '0, 0, "rst_b");

        // input 2 -> output 1, three flits
        d = p5(0, 0, 1, 0, 0);
        step(1, 1, 5'b00100, d, 5'b00000, '0, 5'b00000, idle_sw,            5'b00000, 0, "s1_arb");
        step(1, 1, 5'b00100, d, 5'b00000, '0, 5'b00100, p5(S, 2, S, S, S),  5'b00010, 0, "s1_f1");
        step(1, 1, 5'b00100, d, 5'b00000, '0, 5'b00100, p5(S, 2, S, S, S),  5'b00010, 0, "s1_f2");
        step(1, 1, 5'b00100, d, 5'b00100, '0, 5'b00100, p5(S, 2, S, S, S),  5'b00010, 0, "s1_tail");
        step(1, 1, 5'b00000, d, 5'b00000, '0, 5'b00000, idle_sw,            5'b00000, 0, "s1_rel");

        // inputs 0,2,3 -> output 4, single-flit packets: order 0,2,3,0
        d = p5(4, 0, 4, 4, 0);
        step(1, 1, 5'b01101, d, 5'b01101, '0, 5'b00000, idle_sw,            5'b00000, 0, "rr_c0");
        step(1, 1, 5'b01101, d, 5'b01101, '0, 5'b00001, p5(S, S, S, S, 0),  5'b10000, 0, "rr_g0");
        step(1, 1, 5'b01101, d, 5'b01101, '0, 5'b00000, idle_sw,            5'b00000, 0, "rr_b0");
        step(1, 1, 5'b01101, d, 5'b01101, '0, 5'b00100, p5(S, S, S, S, 2),  5'b10000, 0, "rr_g2");
        step(1, 1, 5'b01101, d, 5'b01101, '0, 5'b00000, idle_sw,            5'b00000, 0, "rr_b1");
        step(1, 1, 5'b01101, d, 5'b01101, '0, 5'b01000, p5(S, S, S, S, 3),  5'b10000, 0, "rr_g3");
        step(1, 1, 5'b01101, d, 5'b01101, '0, 5'b00000, idle_sw,            5'b00000, 0, "rr_b2");
        step(1, 1, 5'b01101, d, 5'b01101, '0, 5'b00001, p5(S, S, S, S, 0),  5'b10000, 0, "rr_wrap");
        step(1, 1, 5'b00000, d, 5'b00000, '0, 5'b00000, idle_sw,            5'b00000, 0, "rr_end");

        // output 1: inputs 3 and 4 compete, pointer at 3; busy stalls owner 3
        d = p5(0, 0, 0, 1, 1);
        step(1, 1, 5'b11000, d, 5'b00000, 5'b00000, 5'b00000, idle_sw,           5'b00000, 0, "bz_arb");
        step(1, 1, 5'b11000, d, 5'b00000, 5'b00000, 5'b01000, p5(S, 3, S, S, S), 5'b00010, 0, "bz_f1");
        for (int k = 0; k < 4; k++)
            step(1, 1, 5'b11000, d, 5'b00000, 5'b00010, 5'b00000, p5(S, 3, S, S, S), 5'b00010, 0, "bz_stall");
        step(1, 1, 5'b11000, d, 5'b01000, 5'b00000, 5'b01000, p5(S, 3, S, S, S), 5'b00010, 0, "bz_tail");
        step(1, 1, 5'b10000, d, 5'b10000, 5'b00000, 5'b00000, idle_sw,           5'b00000, 0, "bz_bubble");
        step(1, 1, 5'b10000, d, 5'b10000, 5'b00000, 5'b10000, p5(S, 4, S, S, S), 5'b00010, 0, "bz_next");
        step(1, 1, 5'b00000, d, 5'b00000, 5'b00000, 5'b00000, idle_sw,           5'b00000, 0, "bz_end");

        // en low freezes out2 lock to input 0 and blocks input 1's request to output 3
        d = p5(2, 3, 0, 0, 0);
        step(1, 1, 5'b00001, d, 5'b00000, '0, 5'b00000, idle_sw,           5'b00000, 0, "en_arb");
        step(1, 1, 5'b00001, d, 5'b00000, '0, 5'b00001, p5(S, S, 0, S, S), 5'b00100, 0, "en_f1");
        for (int k = 0; k < 3; k++)
            step(1, 0, 5'b00011, d, 5'b00000, '0, 5'b00000, p5(S, S, 0, S, S), 5'b00100, 0, "en_off");
        step(1, 1, 5'b00011, d, 5'b00001, '0, 5'b00001, p5(S, S, 0, S, S), 5'b00100, 0, "en_resume");
        step(1, 1, 5'b00010, d, 5'b00010, '0, 5'b00010, p5(S, S, S, 1, S), 5'b01000, 0, "en_out3");
        step(1, 1, 5'b00000, d, 5'b00000, '0, 5'b00000, idle_sw,           5'b00000, 0, "en_end");

        // illegal destination: never granted, sticky error
        d = p5(0, 6, 0, 0, 0);
        step(1, 1, 5'b00010, d, 5'b00000, '0, 5'b00000, idle_sw, 5'b00000, 0, "ill_c0");
        step(1, 1, 5'b00010, d, 5'b00000, '0, 5'b00000, idle_sw, 5'b00000, 1, "ill_c1");
        step(1, 1, 5'b00000, d, 5'b00000, '0, 5'b00000, idle_sw, 5'b00000, 1, "ill_sticky");

        // async reset mid-packet on output 0, then pointers restart at 0
        d = p5(0, 0, 0, 0, 0);
        step(1, 1, 5'b10000, d, 5'b00000, '0, 5'b00000, idle_sw,           5'b00000, 1, "ar_arb");
        step(1, 1, 5'b10000, d, 5'b00000, '0, 5'b10000, p5(4, S, S, S, S), 5'b00001, 1, "ar_f1");
        step(0, 1, 5'b10000, d, 5'b00000, '0, 5'b00000, idle_sw,           5'b00000, 0, "ar_drop");
        step(1, 1, 5'b00000, d, 5'b00000, '0, 5'b00000, idle_sw,           5'b00000, 0, "ar_idle");
        d = p5(4, 0, 4, 0, 0);
        step(1, 1, 5'b00101, d, 5'b00101, '0, 5'b00000, idle_sw,           5'b00000, 0, "ar_arb2");
        step(1, 1, 5'b00101, d, 5'b00101, '0, 5'b00001, p5(S, S, S, S, 0), 5'b10000, 0, "ar_ptr0");
        step(1, 1, 5'b00000, d, 5'b00000, '0, 5'b00000, idle_sw,           5'b00000, 0, "ar_end");

        for (int k = 0; k < 4 && sb.size() != 0; k++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
